// File: rtl/icache_direct_pkg.sv
// Shared types for the instruction cache: ibus/cbus request and response
// structs, cbus size/length encodings with helpers, and the cache FSM states.
package icache_direct_pkg;

    // Transfer size per beat on cbus.
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    // Burst length on cbus is encoded as (beats - 1).
    typedef logic [3:0] mlen_t;
    localparam mlen_t MLEN1  = 4'd0;
    localparam mlen_t MLEN2  = 4'd1;
    localparam mlen_t MLEN4  = 4'd3;
    localparam mlen_t MLEN8  = 4'd7;
    localparam mlen_t MLEN16 = 4'd15;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        mlen_t       len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

    // Burst-length encoding for a given number of beats (1..16).
    function automatic mlen_t mlen_for_beats(input int unsigned beats);
        return mlen_t'(beats - 32'd1);
    endfunction

    // Size encoding for a given beat width in bytes.
    function automatic msize_t msize_for_bytes(input int unsigned bytes);
        case (bytes)
            32'd1:   return MSIZE1;
            32'd2:   return MSIZE2;
            32'd4:   return MSIZE4;
            default: return MSIZE8;
        endcase
    endfunction

endpackage

// File: rtl/icache_line_ram.sv
// Line data storage: SETS x WORDS x 64-bit flops, one word-wide write port
// and a combinational read of a whole line.
module icache_line_ram #(
    parameter int SETS  = 16,
    parameter int WORDS = 4
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [$clog2(SETS)-1:0]      wr_idx,
    input  logic [$clog2(WORDS)-1:0]     wr_word,
    input  logic [63:0]                  wr_data,
    input  logic [$clog2(SETS)-1:0]      rd_idx,
    output logic [WORDS-1:0][63:0]       rd_line
);

    logic [WORDS-1:0][63:0] mem_q [SETS];
    logic [WORDS-1:0][63:0] mem_d [SETS];

    // Next array contents: a single word is replaced when a refill beat lands.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx][wr_word] = wr_data;
        end
    end

    // Data array register; never reset, lines are qualified by the valid bits.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_line = mem_q[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache. Hits answer combinationally in
// the request cycle; misses refill the whole line with one cbus burst and the
// request is looked up again once the cache is back in IDLE.
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int WORDS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    output cbus_req_t  creq,
    input  cbus_resp_t cresp
);

    localparam int WSEL = $clog2(WORDS);
    localparam int OFF  = 3 + WSEL;
    localparam int IDX  = $clog2(SETS);
    localparam int TAG  = 64 - OFF - IDX;

    localparam mlen_t LINE_LEN = mlen_for_beats(WORDS);

    // Address fields of the incoming request.
    logic [IDX-1:0]  req_idx;
    logic [TAG-1:0]  req_tag;
    logic [WSEL-1:0] req_word;
    logic            req_half;

    assign req_idx  = ireq.addr[OFF +: IDX];
    assign req_tag  = ireq.addr[63 -: TAG];
    assign req_word = ireq.addr[OFF-1:3];
    assign req_half = ireq.addr[2];

    // Byte-in-half bits never select anything for 32-bit fetches.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ireq.addr[1:0];

    // Control state.
    icache_state_t   state_q, state_d;
    logic [WSEL-1:0] cnt_q, cnt_d;
    logic [SETS-1:0] valid_q, valid_d;

    // Refill bookkeeping and tag storage (not reset).
    logic [63:0]              line_addr_q, line_addr_d;
    logic [IDX-1:0]           idx_q, idx_d;
    logic [TAG-1:0]           tag_q, tag_d;
    logic [SETS-1:0][TAG-1:0] tags_q, tags_d;

    // Line array interface.
    logic                   ram_we;
    logic [WORDS-1:0][63:0] rd_line;
    logic [63:0]            sel_word;
    logic                   hit;

    icache_line_ram #(
        .SETS  (SETS),
        .WORDS (WORDS)
    ) u_line_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_idx  (idx_q),
        .wr_word (cnt_q),
        .wr_data (cresp.data),
        .rd_idx  (req_idx),
        .rd_line (rd_line)
    );

    assign sel_word = rd_line[req_word];
    assign hit      = ireq.valid && (state_q == IDLE) && valid_q[req_idx]
                      && (tags_q[req_idx] == req_tag);

    // Core-side response: same-cycle hit answer, zeros otherwise.
    always_comb begin
        iresp = '0;
        if (hit) begin
            iresp.addr_ok = 1'b1;
            iresp.data_ok = 1'b1;
            iresp.data    = req_half ? sel_word[63:32] : sel_word[31:0];
        end
    end

    // Memory-side request: one full-line burst read held for the whole FETCH.
    always_comb begin
        creq = '0;
        if (state_q == FETCH) begin
            creq.valid    = 1'b1;
            creq.is_write = 1'b0;
            creq.size     = MSIZE8;
            creq.addr     = line_addr_q;
            creq.strobe   = '0;
            creq.data     = '0;
            creq.len      = LINE_LEN;
        end
    end

    // Next-state logic: miss detection, beat writes, line commit on last, reset.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        line_addr_d = line_addr_q;
        idx_d       = idx_q;
        tag_d       = tag_q;
        tags_d      = tags_q;
        ram_we      = 1'b0;

        case (state_q)
            IDLE: begin
                if (ireq.valid && !hit) begin
                    line_addr_d      = {ireq.addr[63:OFF], {OFF{1'b0}}};
                    idx_d            = req_idx;
                    tag_d            = req_tag;
                    cnt_d            = '0;
                    // The victim's words are about to be overwritten, so it
                    // must not remain hittable if the refill is abandoned.
                    valid_d[req_idx] = 1'b0;
                    state_d          = FETCH;
                end
            end
            FETCH: begin
                if (cresp.ready) begin
                    ram_we = 1'b1;
                    cnt_d  = cnt_q + WSEL'(1);
                    if (cresp.last) begin
                        valid_d[idx_q] = 1'b1;
                        tags_d[idx_q]  = tag_q;
                        state_d        = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset overrides a simultaneous last: the burst is dropped uncommitted.
        if (reset) begin
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = '0;
            ram_we  = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        state_q     <= state_d;
        cnt_q       <= cnt_d;
        valid_q     <= valid_d;
        line_addr_q <= line_addr_d;
        idx_q       <= idx_d;
        tag_q       <= tag_d;
        tags_q      <= tags_d;
    end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: a burst memory responder, a line-residency model
// of the cache checked every cycle, and directed plus randomized fetches.
module tb_icache_direct;
    import icache_direct_pkg::*;

    localparam int SETS   = 16;
    localparam int WORDS  = 4;
    localparam int LINE_B = 8 * WORDS;

    logic       clk = 1'b0;
    logic       reset;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    cbus_req_t  creq;
    cbus_resp_t cresp;

    icache_direct #(.SETS(SETS), .WORDS(WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .creq  (creq),
        .cresp (cresp)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Memory contents: every 64-bit word is a function of its own address.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return {~a[31:0], a[31:0] ^ 32'h1234_5678};
    endfunction

    function automatic logic [31:0] exp_half(input logic [63:0] a);
        logic [63:0] w;
        w = mem_word({a[63:3], 3'b000});
        return a[2] ? w[63:32] : w[31:0];
    endfunction

    // ---------------- memory responder ----------------
    int rmode = 0;   // 0: ready every cycle, 1: every other cycle, 2: random
    int rbeat = 0;
    bit tog   = 1'b0;

    always @(posedge clk) begin
        if (reset) rbeat = 0;
        else if (cresp.ready) rbeat = cresp.last ? 0 : rbeat + 1;
        tog = ~tog;
        #1;
        cresp = '0;
        if (creq.valid) begin
            if ((rmode == 0) || (rmode == 1 && tog) || (rmode == 2 && $urandom_range(0, 2) != 0)) begin
                cresp.ready = 1'b1;
                cresp.data  = mem_word(creq.addr + 64'(8 * rbeat));
                cresp.last  = (rbeat == WORDS - 1);
            end
        end
    end

    // ---------------- behavioural model ----------------
    // Which memory line (addr / LINE_B) each set holds, and whether a refill
    // is outstanding for some line.
    bit          m_valid [SETS];
    logic [63:0] m_line  [SETS];
    bit          busy = 1'b0;
    logic [63:0] pline;
    int          cyc = 0;
    int          last_cyc = -1;

    function automatic bit m_hit(input logic [63:0] a);
        logic [63:0] ln;
        ln = a / LINE_B;
        return m_valid[ln % SETS] && (m_line[ln % SETS] == ln);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            busy = 1'b0;
            for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
        end else if (busy) begin
            if (cresp.ready && cresp.last) begin
                m_valid[pline % SETS] = 1'b1;
                m_line[pline % SETS]  = pline;
                busy     = 1'b0;
                last_cyc = cyc;
            end
        end else if (ireq.valid && !m_hit(ireq.addr)) begin
            pline = ireq.addr / LINE_B;
            m_valid[pline % SETS] = 1'b0;
            busy = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit          chk_en  = 1'b0;
    bit          prev_cv = 1'b0;
    int          n_req   = 0;
    logic [63:0] req_log [256];

    always @(negedge clk) begin
        bit exp_hit;
        if (chk_en) begin
            exp_hit = !busy && ireq.valid && m_hit(ireq.addr);
            chk("data_ok", iresp.data_ok, exp_hit);
            chk("addr_ok", iresp.addr_ok, exp_hit);
            chk("data", iresp.data, exp_hit ? exp_half(ireq.addr) : 32'h0);
            chk("creq_valid", creq.valid, busy);
            if (busy) begin
                chk("creq_addr", creq.addr, pline * LINE_B);
                chk("creq_is_write", creq.is_write, 1'b0);
                chk("creq_size", creq.size, MSIZE8);
                chk("creq_len", creq.len, 4'd3);
                chk("creq_strobe", creq.strobe, 8'h0);
                chk("creq_data", creq.data, 64'h0);
            end
            if (creq.valid && !prev_cv) begin
                if (n_req < 256) req_log[n_req] = creq.addr;
                n_req++;
            end
            prev_cv = creq.valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ok(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (iresp.data_ok) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic fetch(input logic [63:0] a);
        @(posedge clk); #1;
        ireq.valid = 1'b1;
        ireq.addr  = a;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached, checks %0d", n_chk);
        $fatal(1);
    end

    initial begin
        bit          ok;
        bit          got;
        int          n0;
        logic [31:0] lit [8];
        lit = '{32'h9234_5678, 32'h7FFF_FFFF, 32'h9234_5670, 32'h7FFF_FFF7,
                32'h9234_5668, 32'h7FFF_FFEF, 32'h9234_5660, 32'h7FFF_FFE7};

        reset = 1'b1;
        ireq  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_creq_valid", creq.valid, 1'b0);
        chk("rst_iresp", iresp, 64'h0);

        // Cold miss, ready every other cycle.
        rmode = 1;
        n0 = n_req;
        fetch(64'h8000_0000);
        wait_ok(200, ok);
        chk("cold_done", ok, 1'b1);
        chk("cold_latency", cyc, last_cyc);
        chk("cold_data", iresp.data, 32'h9234_5678);
        chk("cold_nreq", n_req - n0, 1);
        chk("cold_req_addr", req_log[n0], 64'h8000_0000);

        // Sequential hits within the filled line.
        for (int i = 1; i < 8; i++) begin
            fetch(64'h8000_0000 + 64'(4 * i));
            @(negedge clk);
            chk("seq_ok", iresp.data_ok, 1'b1);
            chk("seq_data", iresp.data, lit[i]);
            chk("seq_no_creq", creq.valid, 1'b0);
        end

        // Conflict on set 0.
        rmode = 2;
        n0 = n_req;
        fetch(64'h8000_0200);
        wait_ok(300, ok);
        chk("conf_fill", ok, 1'b1);
        chk("conf_nreq", n_req - n0, 1);
        fetch(64'h8000_0000);
        @(negedge clk);
        chk("conf_miss", iresp.data_ok, 1'b0);
        wait_ok(300, ok);
        chk("conf_refill", ok, 1'b1);
        chk("conf_nreq2", n_req - n0, 2);
        chk("conf_req_addr", req_log[n0 + 1], 64'h8000_0000);

        // Address switched during a refill.
        fetch(64'h8000_0200);
        wait_ok(300, ok);
        n0 = n_req;
        fetch(64'h8000_0000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (creq.valid) break;
        end
        fetch(64'h8000_0100);
        wait_ok(400, ok);
        chk("sw_done", ok, 1'b1);
        chk("sw_nreq", n_req - n0, 2);
        chk("sw_req0", req_log[n0], 64'h8000_0000);
        chk("sw_req1", req_log[n0 + 1], 64'h8000_0100);
        fetch(64'h8000_0000);
        @(negedge clk);
        chk("sw_hit", iresp.data_ok, 1'b1);
        chk("sw_hit_data", iresp.data, 32'h9234_5678);

        // Reset after beat 2 of a refill.
        rmode = 1;
        n0 = n_req;
        fetch(64'h8000_0040);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (rbeat == 2) break;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_creq", creq.valid, 1'b0);
        wait_ok(300, ok);
        chk("rst_mid_refill", ok, 1'b1);
        chk("rst_mid_nreq", n_req - n0, 2);
        chk("rst_mid_data", iresp.data, 32'h9234_5638);

        // No requests for 20 cycles.
        @(posedge clk); #1;
        ireq.valid = 1'b0;
        ireq.addr  = 64'h8000_0100;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_creq", creq.valid, 1'b0);
            chk("idle_iresp", iresp, 64'h0);
        end

        // Randomized fetch stream; the core holds a request until data_ok.
        rmode = 2;
        got = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            reset = ($urandom_range(0, 499) == 0);
            if (!ireq.valid || got || $urandom_range(0, 15) == 0) begin
                ireq.valid = ($urandom_range(0, 3) != 0);
                ireq.addr  = 64'h8000_0000 + 64'($urandom_range(0, 511) * 4);
                if ($urandom_range(0, 3) == 0) ireq.addr[35:32] = 4'($urandom_range(1, 15));
            end
            @(negedge clk);
            got = iresp.data_ok;
        end

        @(posedge clk); #1;
        reset = 1'b0;
        ireq  = '0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache between the pipeline core's instruction port (`ibus`) and the memory-side cache bus (`cbus`). Hits return the 32-bit instruction in the same cycle as the request. Misses refill a whole line with one burst read, then serve the request from the array. The core's fetch logic stays unchanged: it holds `ireq` until `data_ok`.

## Interface
Parameters:
- `SETS`, default 16: number of lines; power of two.
- `WORDS`, default 4: 64-bit words per line; power of two; line size is 8·WORDS bytes.

Ports:
- `clk` in, 1: clock.
- `reset` in, 1: reset, synchronous, active-high.
- `ireq` in, `ibus_req_t`: `valid`, `addr[63:0]`.
- `iresp` out, `ibus_resp_t`: `addr_ok`, `data_ok`, `data[31:0]`.
- `creq` out, `cbus_req_t`: `valid`, `is_write`, `size`, `addr`, `strobe`, `data`, `len`.
- `cresp` in, `cbus_resp_t`: `ready`, `last`, `data[63:0]`.

## Operation
- Address split:
  - offset = `addr[OFF-1:0]`, where OFF = 3 + log2(WORDS).
  - index = next log2(SETS) bits.
  - tag = the remaining upper bits.
  - Word select is `addr[OFF-1:3]`. Half select is `addr[2]`: 0 gives `data[31:0]` of the word, 1 gives `data[63:32]`.
- Storage per line: `valid`, `tag`, and WORDS×64-bit data, all in flops. Array reads are combinational.
- Hit condition: `ireq.valid`, state IDLE, line valid, and tag match.
- On a hit: `iresp.addr_ok` = `iresp.data_ok` = 1, `iresp.data` = the selected half, all in the same cycle.
- FSM states:
  - IDLE: on a miss with `ireq.valid`, latch the line-aligned address and index/tag, clear the beat counter, and go to FETCH. `iresp.*_ok` = 0.
  - FETCH: drive `creq`:
    - `valid`=1, `is_write`=0, `size`=MSIZE8.
    - `addr` = latched line-aligned address.
    - `strobe`=0, `data`=0, `len` = the burst encoding of WORDS beats (MLEN for WORDS).
    - On each `cresp.ready`, write `cresp.data` into word[counter] of the latched index and increment the counter modulo WORDS.
    - On `ready && last`, write `valid`=1 and the latched tag, then go to IDLE.
    - The tag and valid bit are written only at `last`. The line stays invalid during the refill, so a partial line is never hit.
- Changes to `ireq` during FETCH are ignored. The refill always runs to completion for the latched address. Once back in IDLE, the current `ireq` is looked up again, so the core simply sees a later hit or a new miss.
- `ireq.valid` = 0 in IDLE: no refill starts, and `iresp` reads all zeros.
- The end of a refill is set only by `cresp.last`. If `last` arrives before WORDS beats, the unfilled words keep their stale data; this is a bus fault and the cache does not check for it.
- Reset:
  - all `valid` bits = 0; state = IDLE; counter = 0.
  - `creq.valid` = 0; `iresp` = 0.
  - Data and tag arrays are not cleared.
  - Reset in the middle of a refill abandons the burst at once, with no line marked valid.

## Timing
- Hit latency: 0 cycles (combinational `data_ok`).
- Miss latency, counted from the first `ireq` cycle:
  - cycle 0: IDLE detects the miss.
  - cycle 1: `creq.valid` rises.
  - N: the cycle in which `ready && last` is sampled.
  - cycle N+1: IDLE, hit, `data_ok` = 1.
- `creq` holds stable from the first cycle of FETCH until the cycle after `last`.
- Simultaneous `reset` and `cresp.last`: reset wins and the line stays invalid.

## Structure
- Add to the `common` package: a `cbus` length/size encoding helper, if one is not already there, plus the `icache_state_t` enum (IDLE, FETCH).
- Local parameters inside the module: OFF, IDX, TAG widths.
- One sub-module, `icache_line_ram`: a SETS×WORDS×64 flop array with one write port (index, word, data, en) and a combinational read of a whole line. Tag/valid storage stays in the top module.

## Test plan
- Cold miss at 0x8000_0000 with memory returning 4 beats, `ready` on every other cycle, `last` on beat 4:
  - exactly one `creq` with addr 0x8000_0000 and `is_write`=0;
  - `data_ok` first seen the cycle after `last`, with `data` = the low half of beat 0.
- Sequential fetches 0x8000_0004 to 0x8000_001C after that fill:
  - `data_ok`=1 in the same cycle each time;
  - `creq.valid` stays 0;
  - each response is the correct half of the correct beat.
- Conflict, with SETS=16 and WORDS=4: access 0x8000_0200, which has the same index and a new tag:
  - a refill occurs;
  - a following access to 0x8000_0000 misses again.
- `ireq.addr` switched to 0x8000_0100 during the FETCH for 0x8000_0000:
  - the burst for 0x8000_0000 completes;
  - then a second refill for 0x8000_0100 starts;
  - 0x8000_0000 then hits.
- `reset` asserted after beat 2 of a refill:
  - `creq.valid` is 0 the next cycle;
  - a re-access of the same address misses and refills.
- `ireq.valid` = 0 for 20 cycles: `creq.valid` stays 0 and `iresp` is all zeros.
